// File: rtl/uart_decoder_rx.sv
// uart_decoder_rx
// Serial receive decoder for the SoC UART TX line (8 data bits, 1 stop bit, LSB first).
// It recovers each byte from the line and presents it with a one-cycle rx_valid strobe.
// A stop bit sampled low gives a one-cycle frame_err strobe and leaves rx_data unchanged.
// Bit timing is counted in system clock cycles.
//
// Optional feature: define UART_DECODER_PARITY_EN to add one even-parity bit between
// the data bits and the stop bit. A parity mismatch gives frame_err instead of rx_valid.
// The default build (macro undefined) is plain 8N1.
module uart_decoder_rx #(
    parameter int CLK_PERIOD_NS  = 10,
    parameter int BAUD_PERIOD_NS = 4340,
    parameter int CLKS_PER_BIT   = BAUD_PERIOD_NS / CLK_PERIOD_NS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_tx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] rx_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_DECODER_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t           state_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             line_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;
    logic [7:0]       rx_data_r;
    logic             rx_valid_r;
    logic             frame_err_r;
    logic             busy_r;
    logic [15:0]      rx_count_r;
    logic             parity_ok_s;

`ifdef UART_DECODER_PARITY_EN
    logic             par_err_r;

    // Even parity: the transmitted parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    assign parity_ok_s = ~par_err_r;
`else
    assign parity_ok_s = 1'b1;
`endif

    assign line_s    = sync2_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;
    assign rx_count  = rx_count_r;

    // Two-flop synchronizer for the asynchronous line, preset to the idle-high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= uart_tx;
            sync2_r <= sync1_r;
        end
    end

    // Frame decoder FSM: state, bit timing, shift register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= '0;
            idx_r       <= 3'd0;
            shift_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
            rx_count_r  <= 16'h0000;
`ifdef UART_DECODER_PARITY_EN
            par_err_r   <= 1'b0;
`endif
        end else begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= '0;
                    if (!line_s) begin
                        state_r <= ST_START;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_cnt_r == HALF_LAST) begin
                        bit_cnt_r <= '0;
                        if (line_s) begin
                            // Glitch shorter than half a bit: not a real start bit.
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DATA;
                            idx_r   <= 3'd0;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_r      <= '0;
                        shift_r[idx_r] <= line_s;
                        idx_r          <= idx_r + 3'd1;
                        if (idx_r == 3'd7) begin
`ifdef UART_DECODER_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_DECODER_PARITY_EN
                ST_PARITY: begin
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_r <= '0;
                        par_err_r <= (line_s != even_parity(shift_r));
                        state_r   <= ST_STOP;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_r <= '0;
                        if (line_s) begin
                            // Return to IDLE right away so that a back-to-back start bit is caught.
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            if (parity_ok_s) begin
                                rx_data_r  <= shift_r;
                                rx_valid_r <= 1'b1;
                                rx_count_r <= rx_count_r + 16'd1;
                            end else begin
                                frame_err_r <= 1'b1;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_BREAK;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    // A line held low never restarts framing until it returns high.
                    bit_cnt_r <= '0;
                    if (line_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= '0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_decoder_rx.sv
// Self-checking bench for uart_decoder_rx at 434 clocks per bit.
// Expected strobes go into a scoreboard queue when a frame is sent.
// A negedge monitor logs every strobe the DUT produces, and each test task pops both queues and compares them.
module tb_uart_decoder_rx;

    localparam int CPB  = 4340 / 10;
    localparam int HALF = CPB / 2;
`ifdef UART_DECODER_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int LAT    = 3 + HALF + (9 + PBITS) * CPB;
    localparam int BUDGET = 2 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_tx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;
    logic [15:0] rx_count;

    always #5 clk = ~clk;

    uart_decoder_rx dut (
        .clk       (clk),
        .rst       (rst),
        .uart_tx   (uart_tx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .rx_count  (rx_count)
    );

    typedef struct {
        logic        is_err;
        logic [7:0]  data;
        logic [15:0] count;
        int          cyc;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          overlap  = 0;
    logic [7:0]  model_data  = 8'h00;
    logic [15:0] model_count = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) obs_q.push_back('{1'b0, rx_data, rx_count, cyc});
        if (frame_err === 1'b1) obs_q.push_back('{1'b1, rx_data, rx_count, cyc});
        if (rx_valid === 1'b1 && frame_err === 1'b1) overlap++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_good(input logic [7:0] b);
        model_count = model_count + 16'd1;
        model_data  = b;
        exp_q.push_back('{1'b0, b, model_count, 0});
    endtask

    task automatic push_err();
        exp_q.push_back('{1'b1, model_data, model_count, 0});
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic flip_par,
                              output int fall_cyc);
        logic p;
        fall_cyc = cyc;
        uart_tx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_tx = b[i];
            tick(CPB);
        end
        if (PBITS == 1) begin
            p = (^b) ^ flip_par;
            uart_tx = p;
            tick(CPB);
        end
        uart_tx = stop_v;
        tick(CPB);
    endtask

    task automatic wait_obs(input int need, output bit ok);
        int t = 0;
        while (obs_q.size() < need && t < BUDGET) begin
            tick(1);
            t++;
        end
        ok = (obs_q.size() >= need);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uart_tx = 1'b1;
        tick(3);
        n_checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b, expected 00 0 0", rx_data, rx_valid, frame_err);
        end
        n_checks++;
        if (busy !== 1'b0 || rx_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_busy_count: got busy=%b count=%h, expected 0 0000", busy, rx_count);
        end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_single_byte();
        int  f;
        bit  ok;
        ev_t o, e;
        push_good(8'h41);
        send_frame(8'h41, 1'b1, 1'b0, f);
        wait_obs(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_strobe: got no strobe, expected rx_valid within %0d cycles", BUDGET);
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.is_err !== e.is_err || o.data !== e.data || o.count !== e.count) begin
                n_fail++;
                $display("FAIL single_data: got err=%b data=%h count=%h, expected err=%b data=%h count=%h",
                         o.is_err, o.data, o.count, e.is_err, e.data, e.count);
            end
            n_checks++;
            if (o.cyc - f !== LAT) begin
                n_fail++;
                $display("FAIL single_latency: got %0d cycles, expected %0d", o.cyc - f, LAT);
            end
        end
        tick(20);
        n_checks++;
        if (obs_q.size() !== 0 || busy !== 1'b0 || rx_data !== 8'h41) begin
            n_fail++;
            $display("FAIL single_after: got extra=%0d busy=%b data=%h, expected 0 0 41", obs_q.size(), busy, rx_data);
        end
    endtask

    task automatic test_back_to_back();
        int  f1, f2;
        bit  ok;
        ev_t o1, o2, e1, e2;
        push_good(8'h48);
        push_good(8'h69);
        send_frame(8'h48, 1'b1, 1'b0, f1);
        send_frame(8'h69, 1'b1, 1'b0, f2);
        wait_obs(2, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_strobes: got %0d strobes, expected 2", obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            o1 = obs_q.pop_front();
            o2 = obs_q.pop_front();
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            n_checks++;
            if (o1.is_err !== e1.is_err || o1.data !== e1.data || o1.count !== e1.count) begin
                n_fail++;
                $display("FAIL b2b_first: got err=%b data=%h count=%h, expected err=%b data=%h count=%h",
                         o1.is_err, o1.data, o1.count, e1.is_err, e1.data, e1.count);
            end
            n_checks++;
            if (o2.is_err !== e2.is_err || o2.data !== e2.data || o2.count !== e2.count) begin
                n_fail++;
                $display("FAIL b2b_second: got err=%b data=%h count=%h, expected err=%b data=%h count=%h",
                         o2.is_err, o2.data, o2.count, e2.is_err, e2.data, e2.count);
            end
            n_checks++;
            if (o2.cyc - o1.cyc !== (10 + PBITS) * CPB) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d cycles, expected %0d", o2.cyc - o1.cyc, (10 + PBITS) * CPB);
            end
        end
    endtask

    task automatic test_false_start();
        uart_tx = 1'b0;
        tick(50);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL false_start_busy: got busy=%b during low pulse, expected 1", busy);
        end
        tick(50);
        uart_tx = 1'b1;
        tick(CPB);
        n_checks++;
        if (obs_q.size() !== 0 || busy !== 1'b0 || rx_count !== model_count) begin
            n_fail++;
            $display("FAIL false_start_idle: got strobes=%0d busy=%b count=%h, expected 0 0 %h",
                     obs_q.size(), busy, rx_count, model_count);
        end
    endtask

    task automatic test_break();
        int  f;
        bit  ok;
        ev_t o, e;
        push_err();
        send_frame(8'h55, 1'b0, 1'b0, f);
        tick(2000);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL break_busy: got busy=%b while line held low, expected 1", busy);
        end
        wait_obs(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL break_strobe: got no strobe, expected frame_err");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.is_err !== e.is_err || o.data !== e.data || o.count !== e.count) begin
                n_fail++;
                $display("FAIL break_event: got err=%b data=%h count=%h, expected err=%b data=%h count=%h",
                         o.is_err, o.data, o.count, e.is_err, e.data, e.count);
            end
        end
        uart_tx = 1'b1;
        tick(10);
        n_checks++;
        if (obs_q.size() !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_release: got extra=%0d busy=%b, expected 0 0", obs_q.size(), busy);
        end
    endtask

    task automatic test_reset_midframe();
        int  f;
        bit  ok;
        ev_t o, e;
        logic [7:0] b = 8'hA5;
        uart_tx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_tx = b[i];
            tick(CPB);
        end
        uart_tx = b[4];
        tick(HALF);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_busy: got busy=%b in bit 4, expected 1", busy);
        end
        rst = 1'b1;
        uart_tx = 1'b1;
        tick(2);
        n_checks++;
        if (rx_data !== 8'h00 || rx_count !== 16'h0000 || busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: got data=%h count=%h busy=%b valid=%b ferr=%b, expected all zero",
                     rx_data, rx_count, busy, rx_valid, frame_err);
        end
        rst = 1'b0;
        model_count = 16'h0000;
        model_data  = 8'h00;
        tick(20);
        push_good(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, f);
        wait_obs(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL after_reset_strobe: got no strobe, expected rx_valid");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.is_err !== e.is_err || o.data !== e.data || o.count !== e.count) begin
                n_fail++;
                $display("FAIL after_reset_data: got err=%b data=%h count=%h, expected err=%b data=%h count=%h",
                         o.is_err, o.data, o.count, e.is_err, e.data, e.count);
            end
        end
    endtask

`ifdef UART_DECODER_PARITY_EN
    task automatic test_parity();
        int  f;
        bit  ok;
        ev_t o, e;
        push_err();
        send_frame(8'h07, 1'b1, 1'b1, f);
        push_good(8'h07);
        send_frame(8'h07, 1'b1, 1'b0, f);
        wait_obs(2, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL parity_strobes: got %0d strobes, expected 2", obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                n_checks++;
                if (o.is_err !== e.is_err || o.data !== e.data || o.count !== e.count) begin
                    n_fail++;
                    $display("FAIL parity_event%0d: got err=%b data=%h count=%h, expected err=%b data=%h count=%h",
                             k, o.is_err, o.data, o.count, e.is_err, e.data, e.count);
                end
            end
        end
    endtask
`endif

    task automatic test_final();
        tick(20);
        n_checks++;
        if (overlap !== 0 || obs_q.size() !== 0 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL final_state: got overlap=%0d unmatched_obs=%0d unmatched_exp=%0d, expected 0 0 0",
                     overlap, obs_q.size(), exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        uart_tx = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_false_start();
        test_break();
        test_reset_midframe();
`ifdef UART_DECODER_PARITY_EN
        test_parity();
`endif
        test_final();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
